time_seg_display: RTL and testbench

TIME_SEG_DISPLAY -- requirements
Module: time_seg_display

---
 rtl/time_seg_display.sv | 148 ++++++++++++++
 tb/tb_time_seg_display.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/time_seg_display.sv
// Six-digit multiplexed 7-segment driver for an hh.mm.ss time value.
// A free-running scan counter steps through the digits, a shadow register
// captures the time once per frame so a frame never mixes two values, and
// a blink counter can blank the whole display at a slow rate.
module time_seg_display #(
    parameter int TIME_SCAN  = 20_000,
    parameter int TIME_BLINK = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] din,
    input  logic        blink_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    localparam int SCAN_W  = (TIME_SCAN  > 1) ? $clog2(TIME_SCAN)  : 1;
    localparam int BLINK_W = (TIME_BLINK > 1) ? $clog2(TIME_BLINK) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(TIME_SCAN - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(TIME_BLINK - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    logic               scan_end;
    logic [2:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;
    logic               first_load;
    logic [16:0]        shadow;

    logic [5:0]         fval;
    logic               fbad;
    logic               use_tens;
    logic [3:0]         fdig;
    logic [7:0]         seg_next;
    logic [5:0]         sel_next;

    // Active-low segment pattern for one decimal digit, dp off.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    assign scan_end = (scan_cnt == SCAN_LAST);

    // Per-digit dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_end) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit index, 0 (seconds ones) through 5 (hour tens).
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 3'd0;
        end else if (scan_end) begin
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // Frame-boundary capture of the time value, plus one load right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            first_load <= 1'b1;
        end else begin
            first_load <= 1'b0;
            if (first_load || (scan_end && idx == 3'd5)) begin
                shadow <= din;
            end
        end
    end

    // Blink half-period counter; phase runs regardless of blink_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Pick the field and digit for the current index and encode it.
    always_comb begin
        fval     = shadow[5:0];
        fbad     = 1'b0;
        use_tens = 1'b0;
        case (idx)
            3'd0, 3'd1: begin
                fval     = shadow[5:0];
                fbad     = (shadow[5:0] > 6'd59);
                use_tens = (idx == 3'd1);
            end
            3'd2, 3'd3: begin
                fval     = shadow[11:6];
                fbad     = (shadow[11:6] > 6'd59);
                use_tens = (idx == 3'd3);
            end
            default: begin
                fval     = {1'b0, shadow[16:12]};
                fbad     = (shadow[16:12] > 5'd23);
                use_tens = (idx == 3'd5);
            end
        endcase
        fdig     = use_tens ? 4'(fval / 6'd10) : 4'(fval % 6'd10);
        seg_next = fbad ? 8'hBF : seg_code(fdig);
        if (idx == 3'd2 || idx == 3'd4) begin
            seg_next[7] = 1'b0;
        end
        sel_next = ~(6'b000001 << idx);
    end

    // Registered outputs: dark during reset, the post-reset load cycle and blink-off phase.
    always_ff @(posedge clk) begin
        if (rst || first_load) begin
            sel <= 6'b111111;
            seg <= 8'hFF;
        end else if (blink_en && !phase) begin
            sel <= 6'b111111;
            seg <= 8'hFF;
        end else begin
            sel <= sel_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_time_seg_display.sv
// Directed bench for time_seg_display with a short scan (4) and blink (8) period.
module tb_time_seg_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] din;
    logic        blink_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    time_seg_display #(.TIME_SCAN(4), .TIME_BLINK(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .blink_en (blink_en),
        .sel      (sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    localparam logic [16:0] T_A = {5'd12, 6'd34, 6'd56};
    localparam logic [16:0] T_B = {5'd7,  6'd0,  6'd9};
    localparam logic [16:0] T_C = {5'd25, 6'd60, 6'd30};
    localparam logic [16:0] T_D = {5'd23, 6'd59, 6'd61};
    localparam logic [16:0] T_E = {5'd24, 6'd0,  6'd0};

    // Expected seg per index, packed {idx5, idx4, idx3, idx2, idx1, idx0}
    localparam logic [47:0] S_A = {8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82};
    localparam logic [47:0] S_B = {8'hC0, 8'h78, 8'hC0, 8'h40, 8'hC0, 8'h90};
    localparam logic [47:0] S_C = {8'hBF, 8'h3F, 8'hBF, 8'h3F, 8'hB0, 8'hC0};
    localparam logic [47:0] S_D = {8'hA4, 8'h30, 8'h92, 8'h10, 8'hBF, 8'hBF};
    localparam logic [47:0] S_E = {8'hBF, 8'h3F, 8'hC0, 8'h40, 8'hC0, 8'hC0};

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    // Leaves the bench just after the last reset edge, with cyc = 0.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        din      = T_A;
        blink_en = 1'b0;
        rst      = 1'b1;
        step();
        step();
        total++;
        if (sel !== 6'h3F) begin bad++; $display("FAIL reset_sel: got %h want 3f", sel); end
        total++;
        if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h want ff", seg); end
        rst = 1'b0;
        cyc = 0;
        step();
        total++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            bad++; $display("FAIL load_cycle: got sel=%h seg=%h want 3f ff", sel, seg);
        end
        step();
        total++;
        if (sel !== 6'h3E || seg !== 8'h82) begin
            bad++; $display("FAIL first_digit: got sel=%h seg=%h want 3e 82", sel, seg);
        end
    endtask

    // One full frame; digit d is sampled at cycle 4*d+3 after reset release.
    task automatic test_frame(input string name, input logic [16:0] t, input logic [47:0] s);
        logic [5:0] esel;
        logic [7:0] eseg;
        din = t;
        do_reset();
        for (int d = 0; d < 6; d++) begin
            run_to(4 * d + 3);
            esel = ~(6'b000001 << d);
            eseg = s[8*d +: 8];
            total++;
            if (sel !== esel || seg !== eseg) begin
                bad++;
                $display("FAIL %s idx%0d: got sel=%h seg=%h want %h %h", name, d, sel, seg, esel, eseg);
            end
        end
    endtask

    task automatic test_no_tearing();
        din = T_A;
        do_reset();
        run_to(11);
        total++;
        if (seg !== 8'h19) begin bad++; $display("FAIL tear_pre idx2: got %h want 19", seg); end
        din = T_B;
        for (int d = 3; d < 6; d++) begin
            run_to(4 * d + 3);
            total++;
            if (seg !== S_A[8*d +: 8]) begin
                bad++; $display("FAIL tear_old idx%0d: got %h want %h", d, seg, S_A[8*d +: 8]);
            end
        end
        for (int d = 0; d < 6; d++) begin
            run_to(24 + 4 * d + 3);
            total++;
            if (seg !== S_B[8*d +: 8]) begin
                bad++; $display("FAIL tear_new idx%0d: got %h want %h", d, seg, S_B[8*d +: 8]);
            end
        end
    endtask

    task automatic test_frame_edge();
        din = T_A;
        do_reset();
        run_to(23);
        din = T_B;
        run_to(24);
        din = T_C;
        run_to(27);
        total++;
        if (seg !== 8'h90) begin bad++; $display("FAIL edge_take idx0: got %h want 90", seg); end
        run_to(47);
        total++;
        if (seg !== 8'hC0) begin bad++; $display("FAIL edge_take idx5: got %h want c0", seg); end
        run_to(51);
        total++;
        if (seg !== 8'hC0) begin bad++; $display("FAIL edge_next idx0: got %h want c0", seg); end
        run_to(71);
        total++;
        if (seg !== 8'hBF || sel !== 6'h1F) begin
            bad++; $display("FAIL edge_next idx5: got sel=%h seg=%h want 1f bf", sel, seg);
        end
    endtask

    task automatic test_mid_reset();
        din = T_A;
        do_reset();
        run_to(15);
        total++;
        if (sel !== 6'h37) begin bad++; $display("FAIL midrst_pre: got %h want 37", sel); end
        rst = 1'b1;
        step();
        total++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            bad++; $display("FAIL midrst_hold: got sel=%h seg=%h want 3f ff", sel, seg);
        end
        din = T_B;
        rst = 1'b0;
        step();
        total++;
        if (sel !== 6'h3F || seg !== 8'hFF) begin
            bad++; $display("FAIL midrst_load: got sel=%h seg=%h want 3f ff", sel, seg);
        end
        step();
        total++;
        if (sel !== 6'h3E || seg !== 8'h90) begin
            bad++; $display("FAIL midrst_first: got sel=%h seg=%h want 3e 90", sel, seg);
        end
    endtask

    task automatic test_blink();
        logic       blank;
        logic [5:0] esel;
        din      = T_A;
        blink_en = 1'b1;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step();
            blank = (k == 1) || ((((k - 1) / 8) % 2) == 1);
            esel  = blank ? 6'h3F : ~(6'b000001 << (((k - 1) / 4) % 6));
            total++;
            if (sel !== esel || (blank && seg !== 8'hFF)) begin
                bad++; $display("FAIL blink k=%0d: got sel=%h seg=%h want sel=%h", k, sel, seg, esel);
            end
        end
        blink_en = 1'b0;
        step();
        for (int k = 0; k < 40; k++) begin
            step();
            total++;
            if (sel === 6'h3F || seg === 8'hFF) begin
                bad++; $display("FAIL blink_off k=%0d: got sel=%h seg=%h want lit", k, sel, seg);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        din      = '0;
        blink_en = 1'b0;
        test_reset();
        test_frame("frame_123456", T_A, S_A);
        test_frame("frame_070009", T_B, S_B);
        test_frame("frame_bad_hm", T_C, S_C);
        test_frame("frame_bad_s",  T_D, S_D);
        test_frame("frame_hour24", T_E, S_E);
        test_no_tearing();
        test_frame_edge();
        test_mid_reset();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
